cache_ctrl: RTL
===============

# cache_ctrl

Sequencing controller for a 4-line, fully-associative, read-only cache. It holds the tag, data and valid state for each line and services one processor read at a time. On a hit it returns the data. On a miss it fetches the word from memory over a req/ack handshake and refills a victim line. It drives the existing 2-bit LRU tracker (`lru`) through `lruIndex`/`lruEnable`/`lruHit` and takes its victim choice from `lruOut`.

## Interface
- `TAG_W`, 8, address/tag width (one word per line; the full address is the tag)
- `DATA_W`, 16, data word width

- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `cpuReq`  in  1  read request; accepted when `cpuReq && cpuReady` at a rising edge
- `cpuAddr`  in  TAG_W  read address, sampled at acceptance
- `flush`  in  1  invalidate all lines; honoured only in IDLE
- `cpuReady`  out  1  high only in IDLE
- `cpuData`  out  DATA_W  returned word; registered; valid while `cpuDone`=1
- `cpuDone`  out  1  one-cycle completion pulse
- `memReq`  out  1  memory read request
- `memAddr`  out  TAG_W  memory read address
- `memAck`  in  1  memory response strobe; `memData` is valid with it
- `memData`  in  DATA_W  memory read data
- `lruOut`  in  2  least-recently-used line from the LRU tracker
- `lruIndex`  out  2  line to report to the LRU tracker
- `lruEnable`  out  1  LRU update strobe
- `lruHit`  out  1  LRU access/hit qualifier

## Operation
- **State**
  - FSM states: IDLE, LOOKUP, MISS, REFILL, DONE.
  - Per line i (0..3): `valid[i]`, `tag[i]`, `data[i]`.
  - Latched `reqAddr` and 2-bit `victim`.
- **IDLE**
  - `cpuReady`=1.
  - If `flush`=1: clear all `valid`, stay in IDLE. `flush` has priority over `cpuReq`; a request in the same cycle is not accepted.
  - Otherwise, if `cpuReq`=1: latch `reqAddr`=`cpuAddr` and go to LOOKUP.
- **LOOKUP** (one cycle)
  - Compare `reqAddr` against all lines with `valid[i]`=1.
  - If more than one line matches, the lowest index wins. This cannot occur in legal operation.
  - On a hit at line h:
    - `cpuData` <= `data[h]`.
    - Drive `lruEnable`=1, `lruHit`=1, `lruIndex`=h this cycle.
    - Go to DONE.
  - On a miss:
    - `victim` <= the lowest-index invalid line if any line is invalid, else `lruOut` sampled this cycle.
    - No LRU update.
    - Go to MISS.
- **MISS**
  - `memReq`=1 and `memAddr`=`reqAddr`, held until `memAck`.
  - On `memAck`=1:
    - `tag[victim]` <= `reqAddr`.
    - `data[victim]` <= `memData`.
    - `valid[victim]` <= 1.
    - `cpuData` <= `memData`.
    - Go to REFILL.
- **REFILL** (one cycle)
  - `memReq`=0.
  - Drive `lruEnable`=1, `lruHit`=1, `lruIndex`=`victim` so the refilled line becomes MRU.
  - Go to DONE.
- **DONE** (one cycle): `cpuDone`=1, then go to IDLE.
- **LRU port outside LOOKUP-hit and REFILL**: `lruEnable`=0, `lruHit`=0, `lruIndex`=0.
- **Stray `memAck`** (in any state other than MISS) is ignored.
- **`flush`** outside IDLE is ignored and not remembered.
- **Decoding**: `cpuReady`, `memReq`, `cpuDone` and the LRU strobes are decoded from state only, never from inputs.

## Timing
- **Reset (asynchronous)**
  - State=IDLE, all `valid`=0, `cpuData`=0, `reqAddr`=0, `victim`=0.
  - Outputs: `cpuReady`=1, `cpuDone`=0, `memReq`=0, `memAddr`=0, `lruEnable`=0, `lruHit`=0, `lruIndex`=0.
  - Reset mid-miss drops `memReq` immediately, without waiting for a clock edge, and the transaction is abandoned. A later `memAck` is ignored.
- **Hit latency**: request accepted at edge N → LOOKUP in cycle N..N+1 → `cpuDone`=1 in cycle N+1..N+2. `cpuReady` returns to 1 after edge N+2.
- **Miss latency**
  - `memReq` rises after edge N+1.
  - With `memAck` sampled at edge M: REFILL in cycle M..M+1, `cpuDone` in cycle M+1..M+2.
  - Zero-wait memory (`memAck` already high at the first MISS edge) gives `cpuDone` 4 cycles after acceptance.
- **One outstanding request**: `cpuReq` is ignored while `cpuReady`=0.
- **`memAck` rules**: a single-cycle pulse is sufficient. If `memAck` stays high, only the first edge in MISS is used.

## Test plan
- **Cold miss**: after reset, read 0x12 with `memAck` 2 cycles after `memReq` and `memData`=0xBEEF → `memAddr`=0x12, line 0 filled, REFILL drives `lruIndex`=0/`lruHit`=1, `cpuData`=0xBEEF with `cpuDone` 6 cycles after acceptance.
- **Hit**: read 0x12 again → no `memReq`; LOOKUP drives `lruEnable`=1, `lruIndex`=0; `cpuData`=0xBEEF, `cpuDone` 2 cycles after acceptance.
- **Fill and evict**: miss on 0x01, 0x02, 0x03, 0x04 → lines 0..3 filled in order. A fifth miss on 0x05 with `lruOut`=2 → line 2 replaced; a subsequent read of 0x03 misses and 0x01 hits.
- **Flush**: `flush` and `cpuReq` together in IDLE → request not accepted and all lines invalid. A subsequent read of a previously cached address misses.
- **Reset mid-miss**: assert `reset` while `memReq`=1 → `memReq`=0 immediately and `cpuReady`=1. A following `memAck` causes no fill; the next read of that address misses.
- **Stray ack**: pulse `memAck` in IDLE and in LOOKUP → no state change and no line written.

Source files
------------

// File: rtl/cache_ctrl_if.sv
// Bus bundle for cache_ctrl: processor read port, memory refill port and LRU tracker port.
// Handshakes: a cpu read is taken when cpuReq && cpuReady at a rising edge; a memory read holds memReq until memAck is seen at an edge.
interface cache_ctrl_if #(
   parameter int TAG_W  = 8,
   parameter int DATA_W = 16
);
   logic              cpuReq;
   logic [TAG_W-1:0]  cpuAddr;
   logic              flush;
   logic              cpuReady;
   logic [DATA_W-1:0] cpuData;
   logic              cpuDone;
   logic              memReq;
   logic [TAG_W-1:0]  memAddr;
   logic              memAck;
   logic [DATA_W-1:0] memData;
   logic [1:0]        lruOut;
   logic [1:0]        lruIndex;
   logic              lruEnable;
   logic              lruHit;

   modport slave (
      input  cpuReq, cpuAddr, flush, memAck, memData, lruOut,
      output cpuReady, cpuData, cpuDone, memReq, memAddr, lruIndex, lruEnable, lruHit
   );

   modport master (
      output cpuReq, cpuAddr, flush, memAck, memData, lruOut,
      input  cpuReady, cpuData, cpuDone, memReq, memAddr, lruIndex, lruEnable, lruHit
   );
endinterface

// File: rtl/cache_ctrl.sv
// Sequencing controller for a 4-line fully-associative read-only cache.
// Hits return stored data; misses refill a victim line from memory and report it to the LRU tracker.
module cache_ctrl #(
   parameter int TAG_W  = 8,
   parameter int DATA_W = 16
) (
   input  logic         clk,
   input  logic         reset,
   cache_ctrl_if.slave  bus,
   output logic [2:0]   state_o
);
   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_LOOKUP = 3'd1;
   localparam logic [2:0] ST_MISS   = 3'd2;
   localparam logic [2:0] ST_REFILL = 3'd3;
   localparam logic [2:0] ST_DONE   = 3'd4;

   logic [2:0]        state_q, state_d;
   logic [3:0]        valid_q, valid_d;
   logic [TAG_W-1:0]  req_addr_q, req_addr_d;
   logic [1:0]        victim_q, victim_d;
   logic [DATA_W-1:0] cpu_data_q, cpu_data_d;
   logic [TAG_W-1:0]  tag_q  [4];
   logic [DATA_W-1:0] data_q [4];

   logic       hit;
   logic [1:0] hit_idx;
   logic       has_free;
   logic [1:0] free_idx;
   logic       fill_we;
   logic       lookup_hit;
   logic       refill;

   // Descending scan so the lowest matching / lowest invalid index wins.
   always_comb begin
      hit      = 1'b0;
      hit_idx  = 2'd0;
      has_free = 1'b0;
      free_idx = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (valid_q[i] && (tag_q[i] == req_addr_q)) begin
            hit     = 1'b1;
            hit_idx = 2'(i);
         end
         if (!valid_q[i]) begin
            has_free = 1'b1;
            free_idx = 2'(i);
         end
      end
   end

   assign fill_we = (state_q == ST_MISS) && bus.memAck;

   always_comb begin
      state_d    = state_q;
      valid_d    = valid_q;
      req_addr_d = req_addr_q;
      victim_d   = victim_q;
      cpu_data_d = cpu_data_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.flush) begin
               valid_d = 4'b0000;
            end else if (bus.cpuReq) begin
               req_addr_d = bus.cpuAddr;
               state_d    = ST_LOOKUP;
            end
         end
         ST_LOOKUP: begin
            if (hit) begin
               cpu_data_d = data_q[hit_idx];
               state_d    = ST_DONE;
            end else begin
               victim_d = has_free ? free_idx : bus.lruOut;
               state_d  = ST_MISS;
            end
         end
         ST_MISS: begin
            if (bus.memAck) begin
               valid_d[victim_q] = 1'b1;
               cpu_data_d        = bus.memData;
               state_d           = ST_REFILL;
            end
         end
         ST_REFILL: state_d = ST_DONE;
         ST_DONE:   state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         valid_q    <= 4'b0000;
         req_addr_q <= '0;
         victim_q   <= 2'd0;
         cpu_data_q <= '0;
      end else begin
         state_q    <= state_d;
         valid_q    <= valid_d;
         req_addr_q <= req_addr_d;
         victim_q   <= victim_d;
         cpu_data_q <= cpu_data_d;
      end
   end

   // Tag/data storage needs no reset: a line is only read once its valid bit is set.
   always_ff @(posedge clk) begin
      if (fill_we) begin
         tag_q[victim_q]  <= req_addr_q;
         data_q[victim_q] <= bus.memData;
      end
   end

   assign lookup_hit = (state_q == ST_LOOKUP) && hit;
   assign refill     = (state_q == ST_REFILL);

   assign bus.cpuReady  = (state_q == ST_IDLE);
   assign bus.cpuDone   = (state_q == ST_DONE);
   assign bus.cpuData   = cpu_data_q;
   assign bus.memReq    = (state_q == ST_MISS);
   assign bus.memAddr   = (state_q == ST_MISS) ? req_addr_q : '0;
   assign bus.lruEnable = lookup_hit || refill;
   assign bus.lruHit    = lookup_hit || refill;
   assign bus.lruIndex  = refill ? victim_q : (lookup_hit ? hit_idx : 2'd0);
   assign state_o       = state_q;
endmodule
